// File: rtl/gbf_pkg.sv
// gbf_pkg: shared encodings and tile-length clamp for the GBF dual-bank loader.
//   bank_state_t : per-bank EMPTY / FILLING / FULL
//   ST_*         : loader FSM encoding
//   eff_len()    : effective lines per fill (0 or oversize -> depth)
package gbf_pkg;
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    function automatic int eff_len(input int len, input int depth);
        return (len == 0 || len > depth) ? depth : len;
    endfunction
endpackage

// File: rtl/gbf_bank_state.sv
// gbf_bank_state: EMPTY/FILLING/FULL tracker and ready flag for one GBF bank.
//   start_fill : EMPTY -> FILLING
//   fill_done  : FILLING -> FULL, ready set
//   need_data  : FULL -> EMPTY, ready cleared (ignored in other states)
//   flush      : any state -> EMPTY, ready cleared (highest priority)
module gbf_bank_state
    import gbf_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_fill,
    input  logic        fill_done,
    input  logic        need_data,
    input  logic        flush,
    output bank_state_t state,
    output logic        ready
);
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= BANK_EMPTY;
            ready <= 1'b0;
        end else begin
            case (state)
                BANK_EMPTY:   if (start_fill) state <= BANK_FILLING;
                BANK_FILLING: if (fill_done) begin
                    state <= BANK_FULL;
                    ready <= 1'b1;
                end
                BANK_FULL:    if (need_data) begin
                    state <= BANK_EMPTY;
                    ready <= 1'b0;
                end
                default:      state <= BANK_EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/gbf_dual_bank_loader.sv
// gbf_dual_bank_loader: ping-pong writer of a valid/ready line stream into two GBF banks.
//   s_valid/s_ready/s_data : input line stream
//   tile_len               : lines per fill, sampled at fill start
//   finish                 : abort, discard partial fill, both banks EMPTY
//   gbfN_need_data         : consumer releases a FULL bank
//   enNa/weNa/addrNa/w_dataNa : port-A write strobes, one cycle after acceptance
//   bufN_ready/data_avail  : bank-full status
module gbf_dual_bank_loader
    import gbf_pkg::*;
#(
    parameter int GBF_DATA_BITWIDTH = 512,
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int GBF_DEPTH         = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [GBF_ADDR_BITWIDTH:0]   tile_len,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [GBF_DATA_BITWIDTH-1:0] s_data,
    input  logic                         finish,
    input  logic                         gbf1_need_data,
    input  logic                         gbf2_need_data,
    output logic                         en1a,
    output logic                         we1a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
    output logic                         en2a,
    output logic                         we2a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
    output logic                         buf1_ready,
    output logic                         buf2_ready,
    output logic                         data_avail
);
    localparam int LW = GBF_ADDR_BITWIDTH + 1;
    logic [1:0]                   state;
    logic                         bank;
    logic                         next_bank;
    logic                         last;
    logic                         wr_v;
    logic [LW-1:0]                len_q;
    logic [GBF_ADDR_BITWIDTH-1:0] line_cnt;
    logic [GBF_ADDR_BITWIDTH-1:0] wr_addr;
    logic [GBF_DATA_BITWIDTH-1:0] wr_data;
    bank_state_t                  st1;
    bank_state_t                  st2;
    logic empty1, empty2, acc, done, start, sel, active1, active2;

    // bank/next_bank/sel: 0 = bank 1, 1 = bank 2.
    // done fires on the last write strobe; the other bank may start filling on the same edge.
    always_comb begin
        empty1  = st1 == BANK_EMPTY;
        empty2  = st2 == BANK_EMPTY;
        acc     = s_valid && s_ready && !finish;
        done    = state == ST_FILL && last && wr_v;
        sel     = done ? !bank : (((next_bank ? empty2 : empty1)) ? next_bank : !next_bank);
        start   = !finish && (done ? (bank ? empty1 : empty2) : (state != ST_FILL && (empty1 || empty2)));
        active1 = state == ST_FILL && !bank;
        active2 = state == ST_FILL && bank;
    end

    // last: final beat of the tile accepted; blocks further beats and keeps line_cnt at len_q-1.
    assign s_ready    = state == ST_FILL && !last;
    assign en1a       = wr_v && active1;
    assign we1a       = wr_v && active1;
    assign addr1a     = active1 ? wr_addr : '0;
    assign w_data1a   = active1 ? wr_data : '0;
    assign en2a       = wr_v && active2;
    assign we2a       = wr_v && active2;
    assign addr2a     = active2 ? wr_addr : '0;
    assign w_data2a   = active2 ? wr_data : '0;
    assign data_avail = buf1_ready || buf2_ready;

    always_ff @(posedge clk) begin
        if (reset || finish) begin
            state     <= ST_IDLE;
            bank      <= 1'b0;
            next_bank <= 1'b0;
            last      <= 1'b0;
            wr_v      <= 1'b0;
            len_q     <= '0;
            line_cnt  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_v <= acc;
            if (acc) begin
                wr_addr <= line_cnt;
                wr_data <= s_data;
                if ({1'b0, line_cnt} == len_q - 1'b1) last <= 1'b1;
                else line_cnt <= line_cnt + 1'b1;
            end
            if (done) begin
                next_bank <= !bank;
                state     <= ST_WAIT;
            end
            if (start) begin
                state    <= ST_FILL;
                bank     <= sel;
                len_q    <= LW'(eff_len(int'(tile_len), GBF_DEPTH));
                line_cnt <= '0;
                last     <= 1'b0;
                wr_addr  <= '0;
                wr_data  <= '0;
            end
        end
    end

    gbf_bank_state u_bank1 (
        .clk        (clk),
        .reset      (reset),
        .start_fill (start && !sel),
        .fill_done  (done && !bank),
        .need_data  (gbf1_need_data),
        .flush      (finish),
        .state      (st1),
        .ready      (buf1_ready)
    );

    gbf_bank_state u_bank2 (
        .clk        (clk),
        .reset      (reset),
        .start_fill (start && sel),
        .fill_done  (done && bank),
        .need_data  (gbf2_need_data),
        .flush      (finish),
        .state      (st2),
        .ready      (buf2_ready)
    );
endmodule

// File: tb/tb_gbf_dual_bank_loader.sv
// tb_gbf_dual_bank_loader: scoreboard bench for the dual-bank GBF loader.
module tb_gbf_dual_bank_loader;
    localparam int DW = 512;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW:0]   tile_len = 6'd4;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          finish = 1'b0;
    logic          need1 = 1'b0;
    logic          need2 = 1'b0;
    logic          en1a, we1a, en2a, we2a;
    logic [AW-1:0] addr1a, addr2a;
    logic [DW-1:0] w_data1a, w_data2a;
    logic          buf1_ready, buf2_ready, data_avail;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];
    wr_t w1;
    wr_t w2;
    int  n_chk = 0;
    int  n_pass = 0;

    always #5 clk = ~clk;

    gbf_dual_bank_loader dut (
        .clk            (clk),
        .reset          (reset),
        .tile_len       (tile_len),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .finish         (finish),
        .gbf1_need_data (need1),
        .gbf2_need_data (need2),
        .en1a           (en1a),
        .we1a           (we1a),
        .addr1a         (addr1a),
        .w_data1a       (w_data1a),
        .en2a           (en2a),
        .we2a           (we2a),
        .addr2a         (addr2a),
        .w_data2a       (w_data2a),
        .buf1_ready     (buf1_ready),
        .buf2_ready     (buf2_ready),
        .data_avail     (data_avail)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Offer one beat; on acceptance queue the write expected on bank b at address a.
    task automatic send(input int b, input int a);
        logic [DW-1:0] d;
        int n;
        d = rnd();
        n = 0;
        s_valid = 1'b1;
        s_data = d;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("accept_timeout", 0, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (b == 1) q1.push_back('{addr: AW'(a), data: d});
        else q2.push_back('{addr: AW'(a), data: d});
        s_valid = 1'b0;
    endtask

    task automatic tile(input int b, input int n);
        for (int i = 0; i < n; i++) send(b, i);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (en1a || en2a) chk("en_excl", en1a & en2a, 0);
            if (en1a) begin
                chk("we1a", we1a, 1);
                chk("addr2a_idle", addr2a, 0);
                if (q1.size() == 0) chk("wr1_unexpected", 1, 0);
                else begin
                    w1 = q1.pop_front();
                    chk("addr1a", addr1a, w1.addr);
                    chk("data1a", w_data1a, w1.data);
                end
            end else if (we1a) chk("we1a_stray", we1a, 0);
            if (en2a) begin
                chk("we2a", we2a, 1);
                chk("addr1a_idle", addr1a, 0);
                if (q2.size() == 0) chk("wr2_unexpected", 1, 0);
                else begin
                    w2 = q2.pop_front();
                    chk("addr2a", addr2a, w2.addr);
                    chk("data2a", w_data2a, w2.data);
                end
            end else if (we2a) chk("we2a_stray", we2a, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_en1a", en1a, 0);
        chk("rst_we1a", we1a, 0);
        chk("rst_en2a", en2a, 0);
        chk("rst_addr1a", addr1a, 0);
        chk("rst_w_data1a", w_data1a, 0);
        chk("rst_buf1", buf1_ready, 0);
        chk("rst_buf2", buf2_ready, 0);
        chk("rst_avail", data_avail, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        tile(1, 4);
        @(negedge clk);
        chk("t1_s_ready_after_last", s_ready, 0);
        chk("t1_buf1_early", buf1_ready, 0);
        @(negedge clk);
        chk("t1_buf1", buf1_ready, 1);
        chk("t1_avail", data_avail, 1);

        tile(2, 4);
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_wait_s_ready", s_ready, 0);
        chk("t2_buf1", buf1_ready, 1);
        chk("t2_buf2", buf2_ready, 1);
        s_valid = 1'b0;

        need1 = 1'b1;
        @(posedge clk);
        #1;
        need1 = 1'b0;
        @(negedge clk);
        chk("t3_buf1_clr", buf1_ready, 0);
        chk("t3_buf2_kept", buf2_ready, 1);
        chk("t3_s_ready_lag", s_ready, 0);
        @(negedge clk);
        chk("t3_s_ready", s_ready, 1);
        tile(1, 4);
        repeat (3) @(negedge clk);
        chk("t3_buf1", buf1_ready, 1);
        chk("t3_wait", s_ready, 0);

        tile_len = 6'd0;
        need1 = 1'b1;
        need2 = 1'b1;
        @(posedge clk);
        #1;
        need1 = 1'b0;
        need2 = 1'b0;
        tile(2, 32);
        tile_len = 6'd40;
        tile(1, 32);
        repeat (3) @(negedge clk);
        chk("t4_clamp_s_ready", s_ready, 0);
        chk("t4_buf1", buf1_ready, 1);
        chk("t4_buf2", buf2_ready, 1);

        tile_len = 6'd4;
        need2 = 1'b1;
        @(posedge clk);
        #1;
        need2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(2, i);
            @(negedge clk);
            @(negedge clk);
            chk("t5_stall_en2a", en2a, 0);
            chk("t5_buf2", buf2_ready, (i == 3));
            if (i < 3) chk("t5_addr_hold", addr2a, i);
        end

        need1 = 1'b1;
        @(posedge clk);
        #1;
        need1 = 1'b0;
        send(1, 0);
        send(1, 1);
        @(negedge clk);
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        @(negedge clk);
        chk("t6_buf1", buf1_ready, 0);
        chk("t6_buf2", buf2_ready, 0);
        chk("t6_avail", data_avail, 0);
        chk("t6_en1a", en1a, 0);
        chk("t6_en2a", en2a, 0);
        chk("t6_s_ready", s_ready, 0);
        tile(1, 4);
        repeat (3) @(negedge clk);
        chk("t6_refill_buf1", buf1_ready, 1);
        chk("t6_avail_after", data_avail, 1);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
